ll_ptr_pool_arb: RTL and testbench
==================================

LL_PTR_POOL_ARB -- requirements
Module: ll_ptr_pool_arb

Interface
REQ-001 SHALL have parameter A_WIDTH, default 8: pointer width; pool holds 2**A_WIDTH-1 pointers.
REQ-002 SHALL have parameter N_REQ, default 4: number of requester ports, 2..16.
REQ-003 SHALL have port clk_i  in  1  clock.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port alloc_req_i  in  N_REQ  per-requester pointer allocation request, held until granted.
REQ-006 SHALL have port alloc_gnt_o  out  N_REQ  one-hot grant; the pointer is valid on alloc_ptr_o in the same cycle.
REQ-007 SHALL have port alloc_ptr_o  out  A_WIDTH  granted pointer.
REQ-008 SHALL have port free_val_i  in  N_REQ  per-requester pointer release valid.
REQ-009 SHALL have port free_ptr_i  in  N_REQ*A_WIDTH  release pointers, requester i at bits [i*A_WIDTH +: A_WIDTH].
REQ-010 SHALL have port free_rdy_o  out  N_REQ  one-hot release accept; a transfer occurs when val and rdy are both high.
REQ-011 SHALL have port pool_ptr_i  in  A_WIDTH  next free pointer from the pointer storage.
REQ-012 SHALL have port pool_val_i  in  1  storage has a free pointer.
REQ-013 SHALL have port pool_rd_ack_o  out  1  pop the storage head.
REQ-014 SHALL have port pool_add_ptr_o  out  A_WIDTH  pointer returned to the storage.
REQ-015 SHALL have port pool_add_en_o  out  1  push strobe to the storage.
REQ-016 SHALL have port ready_o  out  1  high once the controller is in RUN.

Function
REQ-017 SHALL run a two-state FSM:
- INIT: moves to RUN in the cycle after pool_val_i is first sampled high.
- RUN: terminal until reset.
REQ-018 SHALL, in INIT, hold alloc_gnt_o, free_rdy_o, pool_rd_ack_o and pool_add_en_o at 0, because the storage ignores pushes while it self-initialises.
REQ-019 SHALL, in RUN, choose the allocation winner combinationally by round-robin among asserted alloc_req_i, searching from index alloc_rr upward with wrap-around.
REQ-020 SHALL, in RUN, assert alloc_gnt_o[winner], alloc_ptr_o = pool_ptr_i and pool_rd_ack_o only when pool_val_i=1 and at least one request is present.
REQ-021 SHALL, when pool_val_i=0 (pool exhausted), grant nothing, leave alloc_rr unchanged, and let requesters stall with no loss or duplication of pointers.
REQ-022 SHALL update alloc_rr <= (winner+1) mod N_REQ on the clock edge of every grant.
REQ-023 SHALL grant releases by an independent round-robin: free_rdy_o[winner]=1 for at most one requester per cycle in RUN, with free_rr <= (winner+1) mod N_REQ on each accept.
REQ-024 SHALL drive pool_add_en_o = accept and pool_add_ptr_o = the winner's free_ptr_i slice, combinationally in the same cycle.
REQ-025 SHALL allow an allocation and a release in the same cycle, each independent of the other.
REQ-026 SHALL not forward a released pointer to an allocating requester in the same cycle; it becomes available via the storage on later cycles.
REQ-027 SHALL hold alloc_ptr_o at 0 whenever no grant is asserted.

Reset
REQ-028 SHALL, on rst_i, asynchronously set state=INIT, alloc_rr=0, free_rr=0 and all outputs to 0.
REQ-029 SHALL, when reset is asserted mid-operation, drop grants and strobes immediately; in-flight requests are re-presented after reset.

Configuration
REQ-030 SHALL, when LL_PTR_POOL_STATS_EN is defined, add two outputs:
- in_use_o (A_WIDTH+1 bits): +1 per grant, -1 per accept, unchanged when both occur in the same cycle, reset 0.
- stall_cnt_o (16 bits): counts RUN cycles with a request present and pool_val_i=0; saturates at 16'hFFFF; reset 0.
REQ-031 SHALL, when LL_PTR_POOL_STATS_EN is undefined, omit these ports and counters entirely.

Structure
REQ-032 SHALL place the FSM state enum (INIT, RUN) and the round-robin helper function in package ll_pkg.
REQ-033 SHALL implement both arbiters as two instances of one sub-module, ll_rr_arb (request vector, advance strobe, one-hot grant, registered pointer).

Verification
REQ-034 Before the first pool_val_i=1, alloc_req_i=4'b1111 and free_val_i=4'b0001 -> all grants, rdy and strobes stay 0; ready_o rises one cycle after pool_val_i.
REQ-035 In RUN with alloc_req_i=4'b1111 held for 4 cycles and pool_ptr_i=5,6,7,8 -> grants 0001, 0010, 0100, 1000 carrying pointers 5,6,7,8, with pool_rd_ack_o=1 each cycle.
REQ-036 With pool_val_i=0 and alloc_req_i=4'b0100 -> no grant; when pool_val_i returns with pool_ptr_i=9 -> alloc_gnt_o=4'b0100 and alloc_ptr_o=9 in that cycle.
REQ-037 With free_val_i=4'b1001 and ptrs 3 and 12 -> accepts requester 0 (ptr 3), then requester 3 (ptr 12) on consecutive cycles via pool_add_en_o.
REQ-038 A simultaneous grant and accept with STATS_EN -> in_use_o unchanged; 70000 exhausted-pool cycles -> stall_cnt_o=16'hFFFF.
REQ-039 Asserting rst_i mid-grant -> outputs go to 0 asynchronously; the FSM re-enters INIT.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared definitions for the linked-list pointer pool arbiter:
// controller state encoding and the round-robin search helper.
package ll_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ll_state_e;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // Round-robin search over up to 16 requesters: the first asserted
   // request at or above 'start', wrapping at 'n'. Requires start < n.
   function automatic rr_pick_t rr_pick(input logic [15:0] req,
                                        input logic [3:0]  start,
                                        input logic [4:0]  n);
      rr_pick_t   res;
      logic [4:0] sum;
      logic [4:0] idx;
      res = '0;
      for (int i = 0; i < 16; i++) begin
         sum = 5'(start) + 5'(i);
         idx = (sum >= n) ? (sum - n) : sum;
         if ((5'(i) < n) && !res.found && req[idx[3:0]]) begin
            res.found = 1'b1;
            res.idx   = idx[3:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ll_rr_arb.sv
// Round-robin arbiter slice: combinational one-hot pick from the request
// vector, starting at a registered pointer that advances past the
// winner only when the owner commits the grant (adv_i).
module ll_rr_arb
   import ll_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] gnt_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   rr_pick_t      pick_s;

   // Search for the winner and decode it one-hot.
   always_comb begin
      pick_s = rr_pick(16'(req_i), 4'(ptr_q), 5'(N));
      gnt_o  = '0;
      for (int i = 0; i < N; i++) begin
         gnt_o[i] = pick_s.found && (pick_s.idx == 4'(i));
      end
   end

   // Move the search start to just past a committed winner.
   always_comb begin
      if (adv_i && pick_s.found) begin
         if (pick_s.idx == 4'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = PW'(pick_s.idx + 4'd1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ll_ptr_pool_arb.sv
// Pointer pool controller: arbitrates N_REQ requesters for allocation from
// and release to an external pointer storage. Holds off all traffic until
// the storage reports its first free pointer (storage self-init).
// Optional build macro: LL_PTR_POOL_STATS_EN adds in_use_o / stall_cnt_o.
module ll_ptr_pool_arb
   import ll_pkg::*;
#(
   parameter int A_WIDTH = 8,
   parameter int N_REQ   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_REQ-1:0]         alloc_req_i,
   output logic [N_REQ-1:0]         alloc_gnt_o,
   output logic [A_WIDTH-1:0]       alloc_ptr_o,
   input  logic [N_REQ-1:0]         free_val_i,
   input  logic [N_REQ*A_WIDTH-1:0] free_ptr_i,
   output logic [N_REQ-1:0]         free_rdy_o,
   input  logic [A_WIDTH-1:0]       pool_ptr_i,
   input  logic                     pool_val_i,
   output logic                     pool_rd_ack_o,
   output logic [A_WIDTH-1:0]       pool_add_ptr_o,
   output logic                     pool_add_en_o,
   output logic                     ready_o
`ifdef LL_PTR_POOL_STATS_EN
  ,output logic [A_WIDTH:0]         in_use_o,
   output logic [15:0]              stall_cnt_o
`endif
);

   ll_state_e          state_q;
   ll_state_e          state_d;
   logic               run_s;
   logic               alloc_go_s;
   logic               free_go_s;
   logic [N_REQ-1:0]   alloc_win_s;
   logic [N_REQ-1:0]   free_win_s;
   logic [A_WIDTH-1:0] free_sel_ptr_s;

   assign run_s      = (state_q == ST_RUN);
   // A release never feeds an allocation directly; both sides are independent.
   assign alloc_go_s = run_s && pool_val_i && (|alloc_req_i);
   assign free_go_s  = run_s && (|free_val_i);

   ll_rr_arb #(.N(N_REQ)) u_alloc_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (alloc_req_i),
      .adv_i (alloc_go_s),
      .gnt_o (alloc_win_s)
   );

   ll_rr_arb #(.N(N_REQ)) u_free_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (free_val_i),
      .adv_i (free_go_s),
      .gnt_o (free_win_s)
   );

   // Select the released pointer of the one-hot release winner.
   always_comb begin
      free_sel_ptr_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         free_sel_ptr_s = free_sel_ptr_s
                        | ({A_WIDTH{free_win_s[i]}} & free_ptr_i[i*A_WIDTH +: A_WIDTH]);
      end
   end

   // Controller state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Leave INIT once the storage has produced its first free pointer.
   always_comb begin
      case (state_q)
         ST_INIT: state_d = pool_val_i ? ST_RUN : ST_INIT;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // Grants, accepts and storage strobes; all quiet outside RUN.
   always_comb begin
      alloc_gnt_o    = alloc_go_s ? alloc_win_s : '0;
      alloc_ptr_o    = alloc_go_s ? pool_ptr_i  : '0;
      pool_rd_ack_o  = alloc_go_s;
      free_rdy_o     = free_go_s ? free_win_s : '0;
      pool_add_en_o  = free_go_s;
      pool_add_ptr_o = free_go_s ? free_sel_ptr_s : '0;
      ready_o        = run_s;
   end

`ifdef LL_PTR_POOL_STATS_EN
   logic [A_WIDTH:0] in_use_q;
   logic [15:0]      stall_cnt_q;

   assign in_use_o    = in_use_q;
   assign stall_cnt_o = stall_cnt_q;

   // Outstanding pointers and saturating exhausted-pool stall counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_use_q    <= '0;
         stall_cnt_q <= 16'h0000;
      end else begin
         case ({alloc_go_s, free_go_s})
            2'b10:   in_use_q <= in_use_q + (A_WIDTH+1)'(1);
            2'b01:   in_use_q <= in_use_q - (A_WIDTH+1)'(1);
            default: in_use_q <= in_use_q;
         endcase
         if (run_s && (|alloc_req_i) && !pool_val_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ll_ptr_pool_arb.sv
// Directed self-checking bench for ll_ptr_pool_arb (A_WIDTH=8, N_REQ=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// before the next rising edge.
module tb_ll_ptr_pool_arb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  alloc_req_i;
   logic [3:0]  alloc_gnt_o;
   logic [7:0]  alloc_ptr_o;
   logic [3:0]  free_val_i;
   logic [31:0] free_ptr_i;
   logic [3:0]  free_rdy_o;
   logic [7:0]  pool_ptr_i;
   logic        pool_val_i;
   logic        pool_rd_ack_o;
   logic [7:0]  pool_add_ptr_o;
   logic        pool_add_en_o;
   logic        ready_o;
`ifdef LL_PTR_POOL_STATS_EN
   logic [8:0]  in_use_o;
   logic [15:0] stall_cnt_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   ll_ptr_pool_arb #(.A_WIDTH(8), .N_REQ(4)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .alloc_req_i    (alloc_req_i),
      .alloc_gnt_o    (alloc_gnt_o),
      .alloc_ptr_o    (alloc_ptr_o),
      .free_val_i     (free_val_i),
      .free_ptr_i     (free_ptr_i),
      .free_rdy_o     (free_rdy_o),
      .pool_ptr_i     (pool_ptr_i),
      .pool_val_i     (pool_val_i),
      .pool_rd_ack_o  (pool_rd_ack_o),
      .pool_add_ptr_o (pool_add_ptr_o),
      .pool_add_en_o  (pool_add_en_o),
      .ready_o        (ready_o)
`ifdef LL_PTR_POOL_STATS_EN
     ,.in_use_o       (in_use_o),
      .stall_cnt_o    (stall_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Allocation side snapshot.
   task automatic check_alloc(input string tag, input logic [3:0] gnt, input logic [7:0] ptr);
      #1;
      check({tag, ".gnt"}, 32'(alloc_gnt_o), 32'(gnt));
      check({tag, ".ptr"}, 32'(alloc_ptr_o), 32'(ptr));
      check({tag, ".ack"}, 32'(pool_rd_ack_o), 32'(|gnt));
   endtask

   // Release side snapshot.
   task automatic check_free(input string tag, input logic [3:0] rdy, input logic [7:0] ptr);
      #1;
      check({tag, ".rdy"}, 32'(free_rdy_o), 32'(rdy));
      check({tag, ".add_en"}, 32'(pool_add_en_o), 32'(|rdy));
      check({tag, ".add_ptr"}, 32'(pool_add_ptr_o), 32'(ptr));
   endtask

   logic [3:0] exp_gnt [4];

   initial begin
      exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010;
      exp_gnt[2] = 4'b0100; exp_gnt[3] = 4'b1000;

      rst_i = 1'b1; alloc_req_i = 4'b0000; free_val_i = 4'b0000;
      free_ptr_i = 32'h0; pool_ptr_i = 8'h00; pool_val_i = 1'b0;
      #3;
      check("rst.ready", 32'(ready_o), 32'd0);
      check_alloc("rst", 4'b0000, 8'd0);
      check_free("rst", 4'b0000, 8'd0);
      tick(); tick();
      rst_i = 1'b0;

      // INIT: requests present but the storage has not come up yet.
      alloc_req_i = 4'b1111; free_val_i = 4'b0001; free_ptr_i = 32'h0000_0003;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_alloc("init", 4'b0000, 8'd0);
         check_free("init", 4'b0000, 8'd0);
         check("init.ready", 32'(ready_o), 32'd0);
      end

      // First pool_val_i: still INIT this cycle.
      free_val_i = 4'b0000; pool_val_i = 1'b1; pool_ptr_i = 8'd5;
      check_alloc("first_val", 4'b0000, 8'd0);
      check("first_val.ready", 32'(ready_o), 32'd0);

      // RUN: rotating grants carrying 5,6,7,8.
      for (int k = 0; k < 4; k++) begin
         tick();
         pool_ptr_i = 8'(5 + k);
         check("run.ready", 32'(ready_o), 32'd1);
         check_alloc("rr", exp_gnt[k], 8'(5 + k));
      end
      tick();
      alloc_req_i = 4'b0000;
      check_alloc("idle", 4'b0000, 8'd0);

      // Pool exhausted: requester 2 stalls, then gets pointer 9.
      pool_val_i = 1'b0; alloc_req_i = 4'b0100;
      check_alloc("empty", 4'b0000, 8'd0);
      tick();
      check_alloc("empty2", 4'b0000, 8'd0);
      pool_val_i = 1'b1; pool_ptr_i = 8'd9;
      check_alloc("refill", 4'b0100, 8'd9);
      tick();
`ifdef LL_PTR_POOL_STATS_EN
      check("stall.one", 32'(stall_cnt_o), 32'd1);
      check("in_use.5", 32'(in_use_o), 32'd5);
`endif
      alloc_req_i = 4'b0000;

      // Releases from requesters 0 and 3 on consecutive cycles.
      free_val_i = 4'b1001; free_ptr_i = {8'd12, 8'd0, 8'd0, 8'd3};
      check_free("rel0", 4'b0001, 8'd3);
      tick();
      free_val_i = 4'b1000;
      check_free("rel3", 4'b1000, 8'd12);
      tick();
      free_val_i = 4'b0000;
      check_free("rel_idle", 4'b0000, 8'd0);

      // Same-cycle grant and accept; released 7 must not appear on alloc_ptr_o.
      alloc_req_i = 4'b0011; pool_ptr_i = 8'd20;
      free_val_i = 4'b0010; free_ptr_i = {8'd0, 8'd0, 8'd7, 8'd0};
      check_alloc("both", 4'b0001, 8'd20);
      check_free("both", 4'b0010, 8'd7);
      tick();
      free_val_i = 4'b0000; alloc_req_i = 4'b0010; pool_ptr_i = 8'd21;
`ifdef LL_PTR_POOL_STATS_EN
      check("in_use.both", 32'(in_use_o), 32'd3);
`endif
      check_alloc("after_both", 4'b0010, 8'd21);
      tick();
      alloc_req_i = 4'b0000;
`ifdef LL_PTR_POOL_STATS_EN
      check("in_use.4", 32'(in_use_o), 32'd4);
      pool_val_i = 1'b0; alloc_req_i = 4'b0001;
      for (int c = 0; c < 70000; c++) begin
         tick();
      end
      check("stall.sat", 32'(stall_cnt_o), 32'hFFFF);
      pool_val_i = 1'b1; alloc_req_i = 4'b0000;
      tick();
`endif

      // Reset asserted while a grant is live.
      alloc_req_i = 4'b0001; pool_ptr_i = 8'd30;
      check_alloc("pre_rst", 4'b0001, 8'd30);
      rst_i = 1'b1;
      check_alloc("async_rst", 4'b0000, 8'd0);
      check("async_rst.ready", 32'(ready_o), 32'd0);
      tick();
      rst_i = 1'b0; alloc_req_i = 4'b0110;
      check_alloc("reinit", 4'b0000, 8'd0);
      check("reinit.ready", 32'(ready_o), 32'd0);
      tick();
      check("rerun.ready", 32'(ready_o), 32'd1);
      check_alloc("rerun", 4'b0010, 8'd30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
